// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bundle shared by the two memory masters
// (CPU datapath and debug loader), the arbiter and the memory macro port.
// The arbiter connects through the slave modport. The master modport is the
// mirror view, used by whatever drives the requests and models the memory.
`timescale 1ns/1ps

interface mem_arbiter_if;
    // CPU master
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wrbits;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_stall;

    // Debug / host loader master
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [3:0]  dbg_wrbits;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;

    // Memory macro port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wrbits;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wrbits,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wrbits,
        output dbg_rdata, dbg_ack,
        output mem_addr, mem_wdata, mem_wrbits, mem_read, mem_write,
        input  mem_rdata
    );

    // Requester / memory-model view
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wrbits,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wrbits,
        input  dbg_rdata, dbg_ack,
        input  mem_addr, mem_wdata, mem_wrbits, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU datapath and the
// debug/host loader.
//
// Each access takes WAIT_CYCLES memory cycles (legal values 1..15) in BUSY.
// It is followed by one DONE cycle that pulses the ack of the granted master.
// Request fields are latched at grant time, so later changes on the master
// inputs cannot affect an access that has already started.
//
// Tie-break between the two masters:
//   MEM_ARBITER_RR_EN defined   : round-robin, so the master that did not win
//                                 last time gets the grant.
//   MEM_ARBITER_RR_EN undefined : fixed priority, and the CPU always wins.
//
// cpu_stall is combinational (cpu_req & ~cpu_ack). It holds the CPU in its
// WB phase, including while a debug access occupies the port.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,   // asynchronous, active low
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter counts down to zero, so it is loaded with one less than
    // the number of memory cycles.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    // Grant encoding: 0 = CPU, 1 = debug
    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DBG = 1'b1;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        grant_q;
    logic        last_grant_q;
    logic [31:0] rdata_q;

    // Request fields latched at grant time
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // Registered output strobes
    logic        mem_read_q;
    logic        mem_write_q;
    logic [3:0]  mem_wrbits_q;
    logic        cpu_ack_q;
    logic        dbg_ack_q;

    // Arbitration result and the selected request fields
    logic        any_req_d;
    logic        grant_d;
    logic        we_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic [3:0]  wrbits_d;

    // Pick a winner among the current requests and mux its request fields
    always_comb begin
        any_req_d = bus.cpu_req | bus.dbg_req;
        grant_d   = GRANT_CPU;

        if (bus.cpu_req && bus.dbg_req) begin
`ifdef MEM_ARBITER_RR_EN
            grant_d = ~last_grant_q;
`else
            grant_d = GRANT_CPU;
`endif
        end else if (bus.dbg_req) begin
            grant_d = GRANT_DBG;
        end

        if (grant_d == GRANT_DBG) begin
            we_d     = bus.dbg_we;
            addr_d   = bus.dbg_addr;
            wdata_d  = bus.dbg_wdata;
            wrbits_d = bus.dbg_wrbits;
        end else begin
            we_d     = bus.cpu_we;
            addr_d   = bus.cpu_addr;
            wdata_d  = bus.cpu_wdata;
            wrbits_d = bus.cpu_wrbits;
        end
    end

`ifndef MEM_ARBITER_RR_EN
    // With fixed priority the grant history only exists for observability.
    // Tie it off here so that it does not appear as a dangling register.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    // Arbiter FSM with registered memory strobes and ack pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            grant_q      <= GRANT_CPU;
            last_grant_q <= GRANT_DBG;
            rdata_q      <= 32'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wrbits_q <= 4'd0;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
        end else begin
            // The acks are single-cycle pulses unless DONE is being entered
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (any_req_d) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        we_q         <= we_d;
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        cnt_q        <= CNT_LOAD;
                        mem_read_q   <= ~we_d;
                        mem_write_q  <= we_d;
                        mem_wrbits_q <= we_d ? wrbits_d : 4'd0;
                        state_q      <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        // The last memory cycle. Read data is valid now.
                        if (!we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        mem_wrbits_q <= 4'd0;
                        cpu_ack_q    <= (grant_q == GRANT_CPU);
                        dbg_ack_q    <= (grant_q == GRANT_DBG);
                        state_q      <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                ST_DONE: begin
                    // Requests are not sampled here. A master still holding
                    // req is arbitrated again on the following IDLE cycle.
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q      <= ST_IDLE;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                    mem_wrbits_q <= 4'd0;
                end
            endcase
        end
    end

    // Memory port is driven from the latched request and registered strobes
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wrbits = mem_wrbits_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;

    // Both masters see the same read-data register. Each master qualifies it
    // with its own ack.
    assign bus.cpu_rdata  = rdata_q;
    assign bus.dbg_rdata  = rdata_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.dbg_ack    = dbg_ack_q;

    // The CPU is held in WB until its own access completes
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_ack_q;

endmodule
